test_pattern_ctrl: RTL and testbench
====================================

# test_pattern_ctrl

Sequencer for the idle test-pattern checker in the decoder receive path. It runs one measurement window per request. For each window it clears the checker, enables it for a programmed number of valid 66-bit blocks, waits one settle cycle, then latches the final mismatch count and a pass/fail verdict against a threshold. It sits between the management/register interface and the checker, and owns the checker's reset, enable and idle-pattern-mode inputs.

## Interface
- NB_MISMATCH_COUNTER, 32, width of checker mismatch count, latched result and threshold
- NB_WINDOW, 32, width of window length and block counter
- i_clock  in  1  block clock, shared with checker
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  request one measurement window; sampled only in IDLE
- i_abort  in  1  cancel running window; wins over i_start
- i_valid  in  1  block-valid strobe, same signal that feeds the checker
- i_window_len  in  NB_WINDOW  number of valid blocks per window; captured on accepted start
- i_error_threshold  in  NB_MISMATCH_COUNTER  max mismatches for pass; captured on accepted start
- i_mismatch_counter  in  NB_MISMATCH_COUNTER  checker count output
- o_checker_reset  out  1  synchronous clear to checker
- o_checker_enable  out  1  checker enable
- o_idle_pattern_mode  out  1  checker idle-pattern mode
- o_busy  out  1  window in progress
- o_done  out  1  one-cycle pulse, results updated
- o_aborted  out  1  one-cycle pulse, window cancelled
- o_error_count  out  NB_MISMATCH_COUNTER  latched mismatch count of last completed window
- o_pass  out  1  o_error_count <= captured threshold
- o_saturated  out  1  latched count is all ones (checker hit its limit)

## Operation
- States: IDLE, CLEAR, RUN, SETTLE.
- IDLE: i_start=1 with i_abort=0 captures window_len and threshold, clears block counter, goes to CLEAR. Otherwise stays in IDLE.
- CLEAR: lasts 1 cycle with o_checker_reset=1. Goes to RUN, or to SETTLE if the captured window_len==0.
- RUN: o_checker_enable=1 and o_idle_pattern_mode=1.
  - Each cycle with i_valid=1 increments the NB_WINDOW block counter.
  - When i_valid=1 and block_count==window_len-1, the state goes to SETTLE. That block is still checked.
- SETTLE: lasts 1 cycle, enable and mode are 0. At its end the block latches o_error_count=i_mismatch_counter, o_pass, o_saturated, pulses o_done next cycle, and returns to IDLE.
- i_abort=1 in CLEAR, RUN or SETTLE forces IDLE next cycle and pulses o_aborted. Latched results and o_done are unchanged.
- i_start outside IDLE is ignored. i_start and i_abort together in IDLE: nothing happens.
- o_checker_enable, o_idle_pattern_mode, o_checker_reset and o_busy decode the state register only. There is no combinational path from inputs.
- o_busy=1 in CLEAR, RUN and SETTLE.
- Block counter never wraps: window ends at window_len. window_len of all ones is legal.
- i_reset: state IDLE. All outputs 0, including o_error_count, o_pass and o_saturated. Counter cleared. Reset mid-window discards the window without an o_aborted pulse.

## Timing
- Start sampled at edge k: CLEAR during cycle k+1 (checker zeroed at edge k+2), RUN from k+2.
- Last valid block sampled in RUN at edge r: SETTLE in cycle r+1, i_mismatch_counter final and latched at edge r+2.
- Cycle r+2: o_done=1, new results visible and held until the next completed window or reset.
- o_busy high cycles k+1..r+1. Next start is accepted at earliest in cycle r+2.
- Minimum window (len 1, valid every cycle): start to o_done = 4 cycles. window_len=0: start to o_done = 3 cycles, count 0, pass=1.
- Abort sampled at edge a: IDLE and o_aborted=1 in cycle a+1, checker disabled from a+1.

## Test plan
- Clean run: len=8, threshold=0, valid every cycle, idle blocks only. Response: o_done at start+11 cycles, o_error_count=0, o_pass=1, o_saturated=0.
- Errors with gapped valid: len=10, threshold=2, valid every other cycle, blocks 3, 5 and 9 corrupted. Response: o_error_count=3, o_pass=0. Exactly 10 enabled valid cycles.
- Abort: len=100, abort after 20 valid blocks. Response: o_aborted pulse one cycle later, no o_done, prior results unchanged, checker enable low. A following start with len=4 completes normally.
- Boundaries:
  - len=0: count 0, pass=1, o_done 3 cycles after start.
  - Start+abort together in IDLE: no state change.
  - Start while busy: ignored.
- Saturation: with a stub checker count of 32'hFFFFFFFF at SETTLE, o_saturated=1 and o_pass=0 for threshold 5.
- Reset mid-RUN: all outputs 0 next cycle, state IDLE, no pulses. A new window after reset reports only its own errors.

Source files
------------

// File: rtl/test_pattern_ctrl.sv
// Measurement-window sequencer for the idle test-pattern checker: clears the checker,
// enables it for a programmed number of valid blocks, then latches count and verdict.
module test_pattern_ctrl #(
   parameter int NB_MISMATCH_COUNTER = 32,
   parameter int NB_WINDOW           = 32
) (
   input  logic                           i_clock,
   input  logic                           i_reset,
   input  logic                           i_start,
   input  logic                           i_abort,
   input  logic                           i_valid,
   input  logic [NB_WINDOW-1:0]           i_window_len,
   input  logic [NB_MISMATCH_COUNTER-1:0] i_error_threshold,
   input  logic [NB_MISMATCH_COUNTER-1:0] i_mismatch_counter,
   output logic                           o_checker_reset,
   output logic                           o_checker_enable,
   output logic                           o_idle_pattern_mode,
   output logic                           o_busy,
   output logic                           o_done,
   output logic                           o_aborted,
   output logic [NB_MISMATCH_COUNTER-1:0] o_error_count,
   output logic                           o_pass,
   output logic                           o_saturated
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_CLEAR  = 2'd1;
   localparam logic [1:0] ST_RUN    = 2'd2;
   localparam logic [1:0] ST_SETTLE = 2'd3;

   localparam logic [NB_WINDOW-1:0] WIN_ONE = NB_WINDOW'(1);

   logic [1:0]                     state_q, state_d;
   logic [NB_WINDOW-1:0]           win_len_q, win_len_d;
   logic [NB_WINDOW-1:0]           blk_cnt_q, blk_cnt_d;
   logic [NB_MISMATCH_COUNTER-1:0] thr_q, thr_d;
   logic [NB_MISMATCH_COUNTER-1:0] err_cnt_q, err_cnt_d;
   logic                           pass_q, pass_d;
   logic                           sat_q, sat_d;
   logic                           done_q, done_d;
   logic                           aborted_q, aborted_d;
   logic                           last_blk;

   // Compare against len-1 so the counter tops out at len and never wraps, even for all-ones.
   assign last_blk = i_valid && (blk_cnt_q == (win_len_q - WIN_ONE));

   always_comb begin
      state_d   = state_q;
      win_len_d = win_len_q;
      blk_cnt_d = blk_cnt_q;
      thr_d     = thr_q;
      err_cnt_d = err_cnt_q;
      pass_d    = pass_q;
      sat_d     = sat_q;
      done_d    = 1'b0;
      aborted_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_start && !i_abort) begin
               state_d   = ST_CLEAR;
               win_len_d = i_window_len;
               thr_d     = i_error_threshold;
               blk_cnt_d = '0;
            end
         end
         ST_CLEAR: begin
            state_d = (win_len_q == '0) ? ST_SETTLE : ST_RUN;
         end
         ST_RUN: begin
            if (i_valid) begin
               blk_cnt_d = blk_cnt_q + WIN_ONE;
               if (last_blk) state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            state_d   = ST_IDLE;
            err_cnt_d = i_mismatch_counter;
            pass_d    = (i_mismatch_counter <= thr_q);
            sat_d     = &i_mismatch_counter;
            done_d    = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort discards the window entirely, including a SETTLE in progress.
      if ((state_q != ST_IDLE) && i_abort) begin
         state_d   = ST_IDLE;
         aborted_d = 1'b1;
         done_d    = 1'b0;
         err_cnt_d = err_cnt_q;
         pass_d    = pass_q;
         sat_d     = sat_q;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q   <= ST_IDLE;
         win_len_q <= '0;
         blk_cnt_q <= '0;
         thr_q     <= '0;
         err_cnt_q <= '0;
         pass_q    <= 1'b0;
         sat_q     <= 1'b0;
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         win_len_q <= win_len_d;
         blk_cnt_q <= blk_cnt_d;
         thr_q     <= thr_d;
         err_cnt_q <= err_cnt_d;
         pass_q    <= pass_d;
         sat_q     <= sat_d;
         done_q    <= done_d;
         aborted_q <= aborted_d;
      end
   end

   assign o_checker_reset     = (state_q == ST_CLEAR);
   assign o_checker_enable    = (state_q == ST_RUN);
   assign o_idle_pattern_mode = (state_q == ST_RUN);
   assign o_busy              = (state_q != ST_IDLE);
   assign o_done              = done_q;
   assign o_aborted           = aborted_q;
   assign o_error_count       = err_cnt_q;
   assign o_pass              = pass_q;
   assign o_saturated         = sat_q;

endmodule

// File: tb/tb_test_pattern_ctrl.sv
// Bench for test_pattern_ctrl: stub checker, window-level reference model checked every
// cycle, and directed windows with hand-computed latencies and results.
module tb_test_pattern_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1, start = 1'b0, abort = 1'b0, valid = 1'b0;
   logic        corrupt = 1'b0, sat_force = 1'b0;
   logic [31:0] wlen = '0, thr = '0, mism;
   logic        ck_rst, ck_en, ck_mode, busy, done, aborted, pass, sat;
   logic [31:0] ecount;
   logic [31:0] stub_cnt;
   int          cyc = 0, ev_cnt = 0, nvec = 0, nbad = 0;

   always #5 clk = ~clk;

   test_pattern_ctrl #(.NB_MISMATCH_COUNTER(32), .NB_WINDOW(32)) dut (
      .i_clock(clk), .i_reset(rst), .i_start(start), .i_abort(abort), .i_valid(valid),
      .i_window_len(wlen), .i_error_threshold(thr), .i_mismatch_counter(mism),
      .o_checker_reset(ck_rst), .o_checker_enable(ck_en), .o_idle_pattern_mode(ck_mode),
      .o_busy(busy), .o_done(done), .o_aborted(aborted), .o_error_count(ecount),
      .o_pass(pass), .o_saturated(sat)
   );

   // Stub checker: counts corrupted blocks it sees while enabled.
   always @(posedge clk) begin
      if (rst || ck_rst) stub_cnt <= '0;
      else if (ck_en && valid && corrupt && stub_cnt != 32'hFFFF_FFFF) stub_cnt <= stub_cnt + 1;
   end
   assign mism = sat_force ? 32'hFFFF_FFFF : stub_cnt;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ck_en && valid) ev_cnt <= ev_cnt + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Window-level model: age counts cycles since the start was accepted.
   bit          m_act = 0, m_done = 0, m_abrt = 0, r_pass = 0, r_sat = 0;
   int          m_age = 0;
   longint      m_blk = 0, m_len = 0;
   logic [31:0] m_thr = '0, m_err = '0, r_cnt = '0;

   initial forever begin
      @(posedge clk);
      m_done = 0;
      m_abrt = 0;
      if (rst) begin
         m_act = 0; m_age = 0; m_blk = 0;
         r_cnt = '0; r_pass = 0; r_sat = 0;
      end else if (m_act) begin
         if (abort) begin
            m_act = 0; m_abrt = 1;
         end else if (m_age >= 2 && m_blk == m_len) begin
            m_act  = 0;
            m_done = 1;
            r_cnt  = sat_force ? 32'hFFFF_FFFF : m_err;
            r_pass = (r_cnt <= m_thr);
            r_sat  = (r_cnt == 32'hFFFF_FFFF);
         end else begin
            if (m_age >= 2 && valid) begin
               m_blk++;
               if (corrupt) m_err++;
            end
            if (m_age < 2) m_age++;
         end
      end else if (start && !abort) begin
         m_act = 1; m_age = 1; m_blk = 0;
         m_len = longint'(wlen); m_thr = thr; m_err = '0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (cyc > 0) begin
         chk("busy",      busy,    m_act);
         chk("ck_reset",  ck_rst,  m_act && m_age == 1);
         chk("ck_enable", ck_en,   m_act && m_age >= 2 && m_blk < m_len);
         chk("idle_mode", ck_mode, m_act && m_age >= 2 && m_blk < m_len);
         chk("done",      done,    m_done);
         chk("aborted",   aborted, m_abrt);
         chk("err_count", ecount,  r_cnt);
         chk("pass",      pass,    r_pass);
         chk("saturated", sat,     r_sat);
      end
   end

   task automatic nxt();
      @(posedge clk);
      #2;
   endtask

   // ev_kind: 0 none, 1 abort, 2 reset, 3 stray start; fired once blk reaches ev_after.
   task automatic run_win(input logic [31:0] len, input logic [31:0] tl, input int gap,
                          input logic [63:0] cmask, input int ev_after, input int ev_kind,
                          output int dcyc);
      int blk, c0;
      dcyc = -1;
      wlen = len; thr = tl; start = 1'b1; c0 = cyc;
      nxt();
      start = 1'b0;
      nxt();
      blk = 0;
      for (int t = 0; t < 400; t++) begin
         if (ev_kind != 0 && blk == ev_after) begin
            valid = 1'b0; corrupt = 1'b0;
            if (ev_kind == 1) abort = 1'b1;
            else if (ev_kind == 2) rst = 1'b1;
            else begin start = 1'b1; wlen = 32'd2; end
            nxt();
            abort = 1'b0; rst = 1'b0; start = 1'b0;
            if (ev_kind != 3) return;
            ev_kind = 0;
         end
         valid   = (t % gap == 0) && (blk < len);
         corrupt = valid && (blk < 64) && cmask[blk];
         if (valid) blk++;
         nxt();
         valid = 1'b0; corrupt = 1'b0;
         if (done) begin
            dcyc = cyc - c0;
            break;
         end
      end
      valid = 1'b0; corrupt = 1'b0;
   endtask

   initial begin
      int d, ev0;
      nxt(); nxt();
      rst = 1'b0;
      nxt();
      chk("rst_busy",  busy,   0);
      chk("rst_count", ecount, 0);
      chk("rst_pass",  pass,   0);
      chk("rst_done",  done,   0);

      run_win(32'd8, 32'd0, 1, 64'h0, 0, 0, d);
      chk("clean_latency", d, 11);
      chk("clean_count", ecount, 0);
      chk("clean_pass", pass, 1);
      chk("clean_sat", sat, 0);

      ev0 = ev_cnt;
      run_win(32'd10, 32'd2, 2, 64'h114, 0, 0, d);
      chk("err_latency", d, 22);
      chk("err_count", ecount, 3);
      chk("err_pass", pass, 0);
      chk("err_enabled_valids", ev_cnt - ev0, 10);

      run_win(32'd100, 32'd50, 1, 64'h0, 20, 1, d);
      chk("abort_pulse", aborted, 1);
      chk("abort_enable", ck_en, 0);
      chk("abort_busy", busy, 0);
      chk("abort_keep_count", ecount, 3);
      chk("abort_no_done", done, 0);
      nxt(); nxt();
      run_win(32'd4, 32'd1, 1, 64'h1, 0, 0, d);
      chk("after_abort_latency", d, 7);
      chk("after_abort_count", ecount, 1);
      chk("after_abort_pass", pass, 1);

      run_win(32'd0, 32'd0, 1, 64'h0, 0, 0, d);
      chk("len0_latency", d, 3);
      chk("len0_count", ecount, 0);
      chk("len0_pass", pass, 1);

      start = 1'b1; abort = 1'b1; wlen = 32'd5;
      nxt();
      start = 1'b0; abort = 1'b0;
      chk("start_abort_idle", busy, 0);
      nxt();

      run_win(32'd6, 32'd0, 1, 64'h0, 2, 3, d);
      chk("busy_start_latency", d, 10);

      sat_force = 1'b1;
      run_win(32'd3, 32'd5, 1, 64'h0, 0, 0, d);
      sat_force = 1'b0;
      chk("sat_count", ecount, 32'hFFFF_FFFF);
      chk("sat_flag", sat, 1);
      chk("sat_pass", pass, 0);

      run_win(32'd50, 32'd0, 1, 64'h1, 5, 2, d);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_count", ecount, 0);
      chk("rst_mid_sat", sat, 0);
      chk("rst_mid_aborted", aborted, 0);
      chk("rst_mid_enable", ck_en, 0);
      run_win(32'd4, 32'd0, 1, 64'h6, 0, 0, d);
      chk("post_rst_latency", d, 7);
      chk("post_rst_count", ecount, 2);
      chk("post_rst_pass", pass, 0);

      nxt(); nxt(); nxt();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
